// File: rtl/uart_transmitter_if.sv
// Byte handshake between a producer and uart_transmitter.
// The producer uses the master modport and the transmitter uses the slave modport.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (output data_in, output data_in_valid, input data_in_ready);
  modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a valid/ready byte input and a registered serial_out.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_transmitter_if.slave  tx_if,
  output logic               serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic ready;
  logic handshake;
  logic bit_end;

  assign ready               = (state_q == IDLE);
  assign handshake           = tx_if.data_in_valid && ready;
  assign bit_end             = (cnt_q == CNT_LAST);
  assign tx_if.data_in_ready = ready;
  assign serial_out          = serial_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        serial_d  = 1'b1;
        if (handshake) begin
          shift_d  = tx_if.data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_if.data_in;
`endif
          serial_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d    = '0;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = PARITY;
`else
            serial_d = 1'b1;
            state_d  = STOP;
`endif
          end else begin
            // The shift register always presents the next data bit at position 0.
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d    = '0;
          serial_d = 1'b1;
          state_d  = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          serial_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: 10 clocks per bit, with serial_out checked on every cycle of each frame.
// The bench follows UART_TX_PARITY_EN when choosing the frame length and the parity bit.
`timescale 1ns/1ps
module tb_uart_transmitter;
  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
  localparam int BT = 10;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = (PAR ? 11 : 10) * BT;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic serial_out;
  int   errors = 0;
  int   checks = 0;

  uart_transmitter_if tx_if ();

  uart_transmitter #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_if      (tx_if),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  // Value the line must carry k cycles after the handshake edge.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int idx;
    idx = k / BT;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit hold_valid,
                            input bit poke, input logic [7:0] poke_val);
    int w;
    int err0;
    err0 = errors;
    tx_if.data_in       = b;
    tx_if.data_in_valid = 1'b1;
    w = 0;
    while (tx_if.data_in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (tx_if.data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait byte=%h: ready=%b required=1", b, tx_if.data_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) tx_if.data_in_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if (poke && k == 30) begin
        tx_if.data_in       = poke_val;
        tx_if.data_in_valid = 1'b1;
      end
      if (poke && k == 40 && !hold_valid) tx_if.data_in_valid = 1'b0;
      checks++;
      if (serial_out !== exp_bit(b, k)) begin
        errors++;
        $display("FAIL serial byte=%h cycle=%0d: got=%b required=%b", b, k, serial_out, exp_bit(b, k));
      end
      checks++;
      if (tx_if.data_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready byte=%h cycle=%0d: got=%b required=0", b, k, tx_if.data_in_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (tx_if.data_in_ready !== 1'b1 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL end_of_frame byte=%h: ready=%b serial=%b required 1/1", b, tx_if.data_in_ready, serial_out);
    end
    $display("tx byte=%h frame_cycles=%0d new_errors=%0d", b, FRAME, errors - err0);
  endtask

  task automatic test_reset();
    tx_if.data_in       = 8'h00;
    tx_if.data_in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (serial_out !== 1'b1 || tx_if.data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: serial=%b ready=%b required 1/1", serial_out, tx_if.data_in_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== 1'b1 || tx_if.data_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle cycle=%0d: serial=%b ready=%b required 1/1", i, serial_out, tx_if.data_in_ready);
      end
    end
    $display("reset+idle 50 cycles done errors=%0d", errors);
  endtask

  task automatic test_send_a5();
    send_frame(8'hA5, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_parity();
    send_frame(8'h07, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 1'b0, 8'h00);
    send_frame(8'hFF, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    tx_if.data_in       = 8'h00;
    tx_if.data_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_if.data_in_valid = 1'b0;
    for (int k = 0; k < 35; k++) begin
      checks++;
      if (serial_out !== exp_bit(8'h00, k)) begin
        errors++;
        $display("FAIL pre_reset cycle=%0d: got=%b required=%b", k, serial_out, exp_bit(8'h00, k));
      end
      @(negedge clk);
    end
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset cycle=35: got=%b required=0", serial_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (serial_out !== 1'b1 || tx_if.data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_frame: serial=%b ready=%b required 1/1", serial_out, tx_if.data_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== 1'b1 || tx_if.data_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cycle=%0d: serial=%b ready=%b required 1/1", i, serial_out, tx_if.data_in_ready);
      end
    end
    $display("reset at frame cycle 35 aborted frame errors=%0d", errors);
    send_frame(8'h3C, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_data_change();
    send_frame(8'h55, 1'b0, 1'b1, 8'hAA);
  endtask

  initial begin
    test_reset();
    test_send_a5();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLOCK_FREQ, default 125_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  8  byte to transmit; sampled only on handshake.
REQ-006 data_in_valid  input  1  producer has a byte on data_in.
REQ-007 data_in_ready  output  1  transmitter can accept a byte this cycle.
REQ-008 serial_out  output  1  UART line, idle high; registered output.

Function
REQ-009 SYMBOL_EDGE_TIME SHALL equal CLOCK_FREQ/BAUD_RATE, integer division truncated; bit counter width SHALL be $clog2(SYMBOL_EDGE_TIME).
REQ-010 States SHALL be IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-011 Handshake SHALL occur on a rising edge where data_in_valid && data_in_ready; data_in is latched into an internal shift register on that edge.
REQ-012 data_in_ready SHALL be 1 exactly when in IDLE, 0 in every other state.
REQ-013 IDLE -> START on handshake; serial_out SHALL go 0 in the first cycle after the handshake edge (latency 1 cycle).
REQ-014 Each bit (start, data, parity, stop) SHALL hold serial_out constant for exactly SYMBOL_EDGE_TIME cycles.
REQ-015 START -> DATA after one bit time; DATA SHALL send 8 bits LSB first, then go to PARITY (macro defined) or STOP.
REQ-016 STOP SHALL drive serial_out 1 for one bit time, then go to IDLE; data_in_ready SHALL be 1 in the cycle after the stop bit ends.
REQ-017 Frame length SHALL be 10*SYMBOL_EDGE_TIME cycles without parity, 11*SYMBOL_EDGE_TIME with parity; handshake-to-next-ready spacing equals frame length.
REQ-018 Back-to-back: if data_in_valid stays 1, the next start bit SHALL begin the cycle after the re-ready handshake; at most one idle-high cycle separates frames beyond the stop bit.
REQ-019 Changes on data_in or data_in_valid while not in IDLE SHALL have no effect on the frame in progress.
REQ-020 In IDLE without handshake serial_out SHALL stay 1 indefinitely.

Reset
REQ-021 rst_n low SHALL immediately, without waiting for clk, force state IDLE, serial_out 1, bit counter and bit index 0, data_in_ready 1.
REQ-022 Reset mid-frame SHALL abort the frame; no partial bits resume after release; first handshake after release starts a fresh frame.
REQ-023 No handshake SHALL be accepted on the edge where rst_n is low.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: PARITY state SHALL send one even-parity bit (XOR of the 8 data bits) between DATA and STOP.
REQ-025 Macro UART_TX_PARITY_EN undefined: PARITY state and its logic SHALL be absent; DATA goes directly to STOP.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so 10 cycles/bit)
REQ-026 Reset then idle 50 cycles -> serial_out=1, data_in_ready=1 throughout.
REQ-027 Send 8'hA5 -> start 0 for 10 cycles, bits 1,0,1,0,0,1,0,1 at 10 cycles each, stop 1; ready returns after 100 cycles (110 with parity, parity bit 0).
REQ-028 Send 8'h07 with UART_TX_PARITY_EN -> parity bit 1; frame 110 cycles.
REQ-029 data_in_valid held 1, bytes 8'h00 then 8'hFF -> second start bit begins within 1 cycle of first stop bit ending; both frames decode correctly.
REQ-030 rst_n pulsed low at cycle 35 of a frame -> serial_out=1 in the same cycle, ready=1; next byte 8'h3C transmits whole.
REQ-031 data_in changed from 8'h55 to 8'hAA mid-frame -> line shows 8'h55 only.
